// File: rtl/ber_test_scheduler.sv
// BER test run sequencer: paced numbered TX words, timed RX matching and error statistics.
// Optional macro BER_SCHED_PRBS_EN selects an LFSR payload instead of the packet index.
module ber_test_scheduler #(
  parameter int W       = 32,
  parameter int PERIOD  = 2000,
  parameter int TIMEOUT = 1500,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset_b,
  input  logic             start,
  input  logic             abort,
  input  logic [15:0]      num_packets,
  output logic [W-1:0]     tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  input  logic [W-1:0]     rx_data,
  input  logic             rx_valid,
  output logic             busy,
  output logic             done,
  output logic [15:0]      pkt_sent,
  output logic [15:0]      pkt_err,
  output logic [15:0]      pkt_lost,
  output logic [CNT_W-1:0] bit_err
);

  localparam int TW = $clog2(PERIOD + 1);

  typedef enum logic [2:0] {IDLE, SEND, WAIT_RX, CHECK, GAP, FIN} state_t;

  state_t         state;
  logic [TW-1:0]  timer;
  logic [15:0]    num_latched;
  logic [W-1:0]   expected;
  logic [W-1:0]   err_vec;
  logic           start_acc;
  logic           handshake;
  logic           period_up;
  logic           timed_out;
  logic           more_pkts;
  logic [5:0]     err_bits;
  logic [CNT_W:0] bit_sum;
  logic [W-1:0]   first_word;
  logic [W-1:0]   next_word;

  function automatic logic [5:0] popcount(input logic [W-1:0] v);
    logic [5:0] c;
    c = '0;
    for (int i = 0; i < W; i++) c = c + 6'(v[i]);
    return c;
  endfunction

  // timer reads k during cycle t0+k, where t0 is the accepted handshake cycle
  assign start_acc = (state == IDLE) && start && !abort;
  assign handshake = (state == SEND) && tx_valid && tx_ready && !abort;
  assign period_up = timer >= TW'(PERIOD - 1);
  assign timed_out = timer >= TW'(TIMEOUT);
  assign more_pkts = pkt_sent < num_latched;
  assign err_bits  = popcount(err_vec);
  assign bit_sum   = {1'b0, bit_err} + (CNT_W+1)'(err_bits);

`ifdef BER_SCHED_PRBS_EN
  localparam logic [31:0] LFSR_SEED = 32'hFFFFFFFF;
  logic [31:0] lfsr;
  logic [31:0] lfsr_step;

  assign lfsr_step  = {lfsr[30:0], ^(lfsr & 32'hF8200000)};
  assign first_word = {1'b1, LFSR_SEED[W-2:0]};
  assign next_word  = {1'b1, lfsr_step[W-2:0]};

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b)       lfsr <= LFSR_SEED;
    else if (start_acc) lfsr <= LFSR_SEED;
    else if (handshake) lfsr <= lfsr_step;
  end
`else
  logic [15:0] next_index;

  assign next_index = pkt_sent + 16'd1;
  assign first_word = {1'b1, {(W-1){1'b0}}};
  assign next_word  = {1'b1, (W-1)'(next_index)};
`endif

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state       <= IDLE;
      timer       <= '0;
      num_latched <= '0;
      expected    <= '0;
      err_vec     <= '0;
      tx_data     <= '0;
      tx_valid    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pkt_sent    <= '0;
      pkt_err     <= '0;
      pkt_lost    <= '0;
      bit_err     <= '0;
    end else begin
      done <= 1'b0;
      // abort wins over everything, and the pending word is simply dropped
      if (state != IDLE && state != FIN && abort) begin
        tx_valid <= 1'b0;
        done     <= 1'b1;
        state    <= FIN;
      end else begin
        case (state)
          IDLE: begin
            if (start_acc) begin
              busy        <= 1'b1;
              num_latched <= num_packets;
              pkt_sent    <= '0;
              pkt_err     <= '0;
              pkt_lost    <= '0;
              bit_err     <= '0;
              timer       <= '0;
              tx_data     <= first_word;
              // an empty run passes through GAP so done lands two cycles after start
              if (num_packets == 16'd0) begin
                state <= GAP;
              end else begin
                tx_valid <= 1'b1;
                state    <= SEND;
              end
            end
          end
          SEND: begin
            if (handshake) begin
              tx_valid <= 1'b0;
              pkt_sent <= pkt_sent + 16'd1;
              expected <= tx_data;
              tx_data  <= next_word;
              timer    <= TW'(1);
              state    <= WAIT_RX;
            end
          end
          WAIT_RX: begin
            timer <= timer + TW'(1);
            if (rx_valid) begin
              err_vec <= rx_data ^ expected;
              state   <= CHECK;
            end else if (timed_out) begin
              pkt_lost <= pkt_lost + 16'd1;
              state    <= GAP;
            end
          end
          CHECK: begin
            timer <= timer + TW'(1);
            if (bit_sum[CNT_W]) bit_err <= '1;
            else                bit_err <= bit_sum[CNT_W-1:0];
            if (err_vec != '0) pkt_err <= pkt_err + 16'd1;
            if (!period_up) begin
              state <= GAP;
            end else if (more_pkts) begin
              tx_valid <= 1'b1;
              state    <= SEND;
            end else begin
              done  <= 1'b1;
              state <= FIN;
            end
          end
          GAP: begin
            timer <= timer + TW'(1);
            if (period_up || pkt_sent == 16'd0) begin
              if (more_pkts) begin
                tx_valid <= 1'b1;
                state    <= SEND;
              end else begin
                done  <= 1'b1;
                state <= FIN;
              end
            end
          end
          FIN: begin
            busy  <= 1'b0;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ber_test_scheduler.sv
// Self-checking bench for ber_test_scheduler: a modem model replays each word with a planned
// delay/bit-flip mask, and run statistics are predicted from that plan.
module tb_ber_test_scheduler;

  localparam int W       = 16;
  localparam int PERIOD  = 40;
  localparam int TIMEOUT = 25;
  localparam int CNT_W   = 8;
  localparam int MAXP    = 32;
  localparam int MAXCNT  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset_b = 1'b1;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [15:0]      num_packets = '0;
  logic [W-1:0]     tx_data;
  logic             tx_valid;
  logic             tx_ready = 1'b0;
  logic [W-1:0]     rx_data = '0;
  logic             rx_valid = 1'b0;
  logic             busy;
  logic             done;
  logic [15:0]      pkt_sent;
  logic [15:0]      pkt_err;
  logic [15:0]      pkt_lost;
  logic [CNT_W-1:0] bit_err;

  int compares = 0;
  int fails = 0;
  int cyc = 0;
  int hs_count = 0;
  int first_hs = -1;
  int last_hs = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int start_cyc = 0;
  int run_d0 = 0;
  int stall_pkt = -1;
  int stall_len = 0;
  int stall_seen = 0;
  int rx_due = 0;
  bit rx_pending = 1'b0;
  bit prev_valid = 1'b0;
  bit held_ok = 1'b0;
  bit tx_seen = 1'b0;
  logic [W-1:0] rx_word = '0;
  logic [W-1:0] held_data = '0;
  int           plan_delay [MAXP];
  logic [W-1:0] plan_mask  [MAXP];

  ber_test_scheduler #(.W(W), .PERIOD(PERIOD), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_b(reset_b), .start(start), .abort(abort), .num_packets(num_packets),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy), .done(done),
    .pkt_sent(pkt_sent), .pkt_err(pkt_err), .pkt_lost(pkt_lost), .bit_err(bit_err)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] expected_word(input int idx);
    logic [31:0] l;
    l = 32'hFFFFFFFF;
`ifdef BER_SCHED_PRBS_EN
    for (int i = 0; i < idx; i++) l = {l[30:0], ^(l & 32'hF8200000)};
`else
    l = 32'(idx);
`endif
    return {1'b1, l[W-2:0]};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    compares++;
    assert (obs === expv) else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic setPlan(input int delay, input logic [W-1:0] mask);
    for (int i = 0; i < MAXP; i++) begin
      plan_delay[i] = delay;
      plan_mask[i]  = mask;
    end
  endtask

  task automatic applyStimulus(input int num);
    hs_count    = 0;
    stall_seen  = 0;
    tx_seen     = 1'b0;
    first_hs    = -1;
    run_d0      = done_cnt;
    num_packets = 16'(num);
    start       = 1'b1;
    start_cyc   = cyc;
    waitCycles(1);
    start       = 1'b0;
    checkOutput("busy_after_start", 32'(busy), 1);
    checkOutput("tx_valid_after_start", 32'(tx_valid), (num != 0) ? 1 : 0);
    checkOutput("clr_pkt_sent", 32'(pkt_sent), 0);
    checkOutput("clr_pkt_err", 32'(pkt_err), 0);
    checkOutput("clr_pkt_lost", 32'(pkt_lost), 0);
    checkOutput("clr_bit_err", 32'(bit_err), 0);
  endtask

  task automatic waitDone(input int bound);
    int g = 0;
    while (done_cnt == run_d0 && g < bound) begin
      waitCycles(1);
      g++;
    end
    checkOutput("done_seen", 32'(done_cnt - run_d0), 1);
    checkOutput("done_high", 32'(done), 1);
    waitCycles(1);
    checkOutput("busy_after_done", 32'(busy), 0);
    checkOutput("done_one_cycle", 32'(done), 0);
  endtask

  task automatic finishRun(input int num);
    int exp_lost = 0;
    int exp_err  = 0;
    int exp_bits = 0;
    for (int i = 0; i < num; i++) begin
      if (plan_delay[i] == 0 || plan_delay[i] > TIMEOUT) begin
        exp_lost++;
      end else begin
        exp_bits += $countones(plan_mask[i]);
        if (plan_mask[i] != '0) exp_err++;
      end
    end
    if (exp_bits > MAXCNT) exp_bits = MAXCNT;
    checkOutput("pkt_sent", 32'(pkt_sent), num);
    checkOutput("pkt_lost", 32'(pkt_lost), exp_lost);
    checkOutput("pkt_err", 32'(pkt_err), exp_err);
    checkOutput("bit_err", 32'(bit_err), exp_bits);
    waitCycles(PERIOD);
    checkOutput("done_once", 32'(done_cnt - run_d0), 1);
    checkOutput("bit_err_hold", 32'(bit_err), exp_bits);
    checkOutput("pkt_err_hold", 32'(pkt_err), exp_err);
  endtask

  // modem model: drives tx_ready/rx, checks words, hold-while-stalled and TX pacing
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      rx_valid = 1'b0;
      rx_data  = W'($urandom);
      if (rx_pending && cyc == rx_due) begin
        rx_valid   = 1'b1;
        rx_data    = rx_word;
        rx_pending = 1'b0;
      end
      tx_ready = !(hs_count == stall_pkt && stall_seen < stall_len);
      if (tx_valid && !prev_valid && hs_count > 0)
        checkOutput("tx_spacing", 32'(cyc - last_hs), PERIOD);
      if (held_ok) begin
        checkOutput("tx_valid_hold", 32'(tx_valid), 1);
        checkOutput("tx_data_hold", 32'(tx_data), 32'(held_data));
      end
      held_ok   = tx_valid && !tx_ready;
      held_data = tx_data;
      if (held_ok) stall_seen++;
      if (tx_valid && tx_ready) begin
        checkOutput("tx_data", 32'(tx_data), 32'(expected_word(hs_count)));
        last_hs = cyc;
        if (hs_count == 0) first_hs = cyc;
        if (plan_delay[hs_count] > 0) begin
          rx_pending = 1'b1;
          rx_due     = cyc + plan_delay[hs_count];
          rx_word    = tx_data ^ plan_mask[hs_count];
        end
        hs_count++;
      end
      if (tx_valid) tx_seen = 1'b1;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      prev_valid = tx_valid;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout: observed no end expected summary");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin
    int a;
    int n;
    setPlan(10, '0);
    #1 reset_b = 1'b0;
    waitCycles(3);
    checkOutput("rst_tx_valid", 32'(tx_valid), 0);
    checkOutput("rst_tx_data", 32'(tx_data), 0);
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_done", 32'(done), 0);
    checkOutput("rst_counters", 32'(pkt_sent | pkt_err | pkt_lost), 0);
    checkOutput("rst_bit_err", 32'(bit_err), 0);
    reset_b = 1'b1;
    waitCycles(3);

    $display("[TB] loopback, 4 packets");
    setPlan(10, '0);
    applyStimulus(4);
    waitDone(4 * PERIOD + 50);
    checkOutput("t1_done_time", 32'(done_cyc), 32'(first_hs + 4 * PERIOD));
    finishRun(4);

    $display("[TB] loopback, packet 2 bits 0 and 3 flipped");
    setPlan(10, '0);
    plan_mask[1] = W'(16'h0009);
    applyStimulus(4);
    waitDone(4 * PERIOD + 50);
    finishRun(4);

    $display("[TB] no returns, 3 packets, start while busy");
    setPlan(0, '0);
    applyStimulus(3);
    waitCycles(50);
    num_packets = 16'd7;
    start = 1'b1;
    waitCycles(1);
    start = 1'b0;
    waitDone(3 * PERIOD + 50);
    checkOutput("t3_done_time", 32'(done_cyc), 32'(last_hs + PERIOD));
    finishRun(3);

    $display("[TB] tx_ready stalled 100 cycles on packet 1");
    setPlan(12, '0);
    stall_pkt = 0;
    stall_len = 100;
    applyStimulus(2);
    waitDone(2 * PERIOD + 200);
    checkOutput("t4_hs_time", 32'(first_hs), 32'(start_cyc + 101));
    checkOutput("t4_done_time", 32'(done_cyc), 32'(last_hs + PERIOD));
    finishRun(2);
    stall_pkt = -1;

    $display("[TB] abort while waiting for packet 2");
    setPlan(10, '0);
    plan_delay[1] = 20;
    plan_mask[1]  = W'(16'h00F0);
    applyStimulus(4);
    n = 0;
    while (hs_count < 2 && n < 3 * PERIOD) begin
      waitCycles(1);
      n++;
    end
    checkOutput("t5_second_hs", 32'(hs_count), 2);
    waitCycles(5);
    abort = 1'b1;
    a = cyc;
    waitCycles(1);
    abort = 1'b0;
    checkOutput("t5_tx_valid_low", 32'(tx_valid), 0);
    waitDone(5);
    checkOutput("t5_done_time", 32'(done_cyc), 32'(a + 1));
    checkOutput("t5_pkt_sent", 32'(pkt_sent), 2);
    checkOutput("t5_pkt_lost", 32'(pkt_lost), 0);
    waitCycles(PERIOD);
    checkOutput("t5_pkt_err_late_rx", 32'(pkt_err), 0);
    checkOutput("t5_bit_err_late_rx", 32'(bit_err), 0);
    checkOutput("t5_no_more_tx", 32'(hs_count), 2);
    checkOutput("t5_done_once", 32'(done_cnt - run_d0), 1);

    $display("[TB] zero packets, start while busy");
    applyStimulus(0);
    num_packets = 16'd5;
    start = 1'b1;
    waitCycles(1);
    start = 1'b0;
    waitDone(10);
    checkOutput("t6_done_time", 32'(done_cyc), 32'(start_cyc + 2));
    checkOutput("t6_tx_never", 32'(tx_seen), 0);
    finishRun(0);

    $display("[TB] randomized runs");
    for (int r = 0; r < 4; r++) begin
      n = $urandom_range(3, 6);
      for (int i = 0; i < n; i++) begin
        case ($urandom_range(0, 9))
          0:       plan_delay[i] = 0;
          1:       plan_delay[i] = TIMEOUT + $urandom_range(1, 4);
          2:       plan_delay[i] = TIMEOUT;
          default: plan_delay[i] = $urandom_range(1, TIMEOUT - 1);
        endcase
        plan_mask[i] = ($urandom_range(0, 2) == 0) ? W'($urandom) : '0;
      end
      stall_pkt = $urandom_range(0, n - 1);
      stall_len = $urandom_range(1, 15);
      applyStimulus(n);
      waitDone(n * PERIOD + 80);
      checkOutput("rnd_done_time", 32'(done_cyc), 32'(last_hs + PERIOD));
      finishRun(n);
    end
    stall_pkt = -1;

    $display("[TB] bit_err saturation");
    setPlan(5, W'(16'hFFFF));
    applyStimulus(17);
    waitDone(17 * PERIOD + 50);
    finishRun(17);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
    $finish;
  end

endmodule
